// File: rtl/clt_randist.sv
// Self-seeded random sample generator: uniform or centred Irwin-Hall (Gaussian)
// samples drawn from an internal 64-bit Fibonacci LFSR, requested through a mode FIFO.
module clt_randist #(
    parameter  int unsigned UW    = 16,
    parameter  int unsigned NSUM  = 12,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned ZW    = UW + $clog2(NSUM) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pushin,
    input  logic          mode_in,
    input  logic          seedload,
    input  logic [63:0]   seed,
    output logic          pushout,
    output logic [ZW-1:0] Z,
    output logic          full,
    output logic          overflow
);

    localparam logic [63:0]   DEFAULT_SEED = 64'h0123_4567_89AB_CDEF;
    localparam int unsigned   PW           = $clog2(DEPTH);
    localparam int unsigned   CW           = $clog2(NSUM + 1);
    localparam logic [PW:0]   FULL_COUNT   = DEPTH[PW:0];
    localparam logic [ZW-1:0] OFFSET       = ZW'(NSUM) << (UW - 1);

    typedef enum logic [1:0] {IDLE, ACC, EMIT} state_t;

    state_t          state_q, state_d;
    logic [63:0]     lfsr_q, lfsr_d;
    logic [DEPTH-1:0] fifo_q, fifo_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            mode_q, mode_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [ZW-1:0]   acc_q, acc_d;
    logic [ZW-1:0]   z_q, z_d;
    logic            pushout_q, pushout_d;

    logic [UW-1:0]   u;
    logic [ZW-1:0]   acc_sum;
    logic            full_w;
    logic            push_ok;
    logic            pop;

    assign u       = lfsr_q[63 -: UW];
    assign acc_sum = acc_q + ZW'(u);
    assign full_w  = (count_q == FULL_COUNT);
    assign push_ok = pushin && !full_w;
    assign pop     = (state_q == IDLE) && (count_q != '0);

    // A push against a full queue is dropped even if a pop frees a slot on the same edge.
    always_comb begin
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (pushin & full_w);
        if (push_ok) begin
            fifo_d[wr_ptr_q] = mode_in;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // The final draw registers Z and pushout directly, so EMIT is the cycle pushout is high.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        z_d       = z_q;
        pushout_d = 1'b0;
        lfsr_d    = lfsr_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    mode_d  = fifo_q[rd_ptr_q];
                    cnt_d   = fifo_q[rd_ptr_q] ? CW'(NSUM) : CW'(1);
                    acc_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                acc_d  = acc_sum;
                cnt_d  = cnt_q - 1'b1;
                lfsr_d = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
                if (cnt_q == CW'(1)) begin
                    z_d       = mode_q ? (acc_sum - OFFSET) : ZW'(u);
                    pushout_d = 1'b1;
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (seedload) begin
            lfsr_d = (seed == '0) ? DEFAULT_SEED : seed;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            lfsr_q     <= DEFAULT_SEED;
            fifo_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            mode_q     <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            z_q        <= '0;
            pushout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            z_q        <= z_d;
            pushout_q  <= pushout_d;
        end
    end

    assign pushout  = pushout_q;
    assign Z        = z_q;
    assign full     = full_w;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_clt_randist.sv
// Self-checking bench for clt_randist: LFSR reference model feeds a scoreboard
// of expected samples; directed steps cover latency, queueing, seeding, reset and statistics.
`timescale 1ns/1ps
module tb_clt_randist;

    localparam int unsigned UW    = 16;
    localparam int unsigned NSUM  = 12;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned ZW    = UW + $clog2(NSUM) + 1;
    localparam int unsigned NSTAT = 3000;
    localparam logic [63:0] DEF_SEED = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] SEED2    = 64'hDEAD_BEEF_CAFE_F00D;

    logic          clk = 1'b0;
    logic          rst;
    logic          pushin;
    logic          mode_in;
    logic          seedload;
    logic [63:0]   seed;
    logic          pushout;
    logic [ZW-1:0] Z;
    logic          full;
    logic          overflow;

    clt_randist #(.UW(UW), .NSUM(NSUM), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pushin(pushin), .mode_in(mode_in),
        .seedload(seedload), .seed(seed), .pushout(pushout), .Z(Z),
        .full(full), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int unsigned   n_assert = 0;
    int unsigned   n_fail   = 0;
    logic [ZW-1:0] exp_q[$];
    int unsigned   po_cyc[$];
    int unsigned   cyc = 0;
    logic [63:0]   m_lfsr;
    bit            stats_on = 1'b0;
    real           s1 = 0.0;
    real           s2 = 0.0;
    int unsigned   n_stat = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [UW-1:0] m_draw();
        logic [UW-1:0] d;
        d      = m_lfsr[63 -: UW];
        m_lfsr = {m_lfsr[62:0], m_lfsr[63] ^ m_lfsr[62] ^ m_lfsr[60] ^ m_lfsr[59]};
        return d;
    endfunction

    function automatic int m_sum(input int unsigned n);
        int s;
        s = 0;
        for (int unsigned i = 0; i < n; i++) s += int'(m_draw());
        return s;
    endfunction

    function automatic logic [ZW-1:0] m_sample(input logic mode);
        int s;
        if (!mode) return ZW'(m_draw());
        s = m_sum(NSUM) - int'(NSUM) * (1 << (UW - 1));
        return ZW'(s);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [ZW-1:0] ez;
        int zs;
        if (rst === 1'b0) begin
            check("no_x", {63'd0, $isunknown({pushout, Z, full, overflow})}, 64'd0);
            if (pushout === 1'b1) begin
                po_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("spurious_pushout", {63'd0, pushout}, 64'd0);
                end else begin
                    ez = exp_q.pop_front();
                    check("Z", 64'(Z), 64'(ez));
                    if (stats_on) begin
                        zs = int'($signed(Z));
                        s1 += real'(zs);
                        s2 += real'(zs) * real'(zs);
                        n_stat++;
                    end
                end
            end
        end
    end

    task automatic push(input logic mode, input bit accept);
        pushin  = 1'b1;
        mode_in = mode;
        if (accept) exp_q.push_back(m_sample(mode));
        @(negedge clk);
        pushin = 1'b0;
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic assert_rst();
        #2;
        rst      = 1'b1;
        pushin   = 1'b0;
        seedload = 1'b0;
        exp_q.delete();
        m_lfsr   = DEF_SEED;
        #1;
    endtask

    task automatic release_rst();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        po_cyc.delete();
    endtask

    task automatic wait_not_full();
        int unsigned n;
        n = 0;
        while (full === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("full_wait", {63'd0, full}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $fatal(1);
    end

    initial begin
        int unsigned e0;
        int          s;
        real         mean, sd, sd_exp;

        rst = 1'b1; pushin = 1'b0; mode_in = 1'b0; seedload = 1'b0; seed = '0;
        m_lfsr = DEF_SEED;
        repeat (3) @(negedge clk);
        check("rst_pushout", {63'd0, pushout}, 64'd0);
        check("rst_Z", 64'(Z), 64'd0);
        check("rst_full", {63'd0, full}, 64'd0);
        check("rst_overflow", {63'd0, overflow}, 64'd0);
        #2 rst = 1'b0;
        @(negedge clk);
        po_cyc.delete();

        // Mode 0 latency and first draws from the default seed
        e0 = cyc + 1;
        push(1'b0, 1'b1);
        drain(20);
        check("m0_count", 64'(po_cyc.size()), 64'd1);
        if (po_cyc.size() > 0) check("m0_latency", 64'(po_cyc[0] - e0), 64'd2);
        check("m0_Z_first", 64'(Z), 64'h0123);
        push(1'b0, 1'b1);
        drain(20);
        check("m0_Z_second", 64'(Z), 64'h0246);

        // Mode 1 latency
        @(negedge clk);
        assert_rst();
        release_rst();
        e0 = cyc + 1;
        push(1'b1, 1'b1);
        drain(40);
        check("m1_count", 64'(po_cyc.size()), 64'd1);
        if (po_cyc.size() > 0) check("m1_latency", 64'(po_cyc[0] - e0), 64'd13);

        // Queue fill and overflow while a mode-1 sum is in progress
        @(negedge clk);
        assert_rst();
        release_rst();
        push(1'b1, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            push(1'b0, i < 8);
            if (i == 6) check("full_after_7", {63'd0, full}, 64'd0);
            if (i == 7) begin
                check("full_after_8", {63'd0, full}, 64'd1);
                check("ovf_after_8", {63'd0, overflow}, 64'd0);
            end
            if (i == 8) begin
                check("full_after_9", {63'd0, full}, 64'd1);
                check("ovf_after_9", {63'd0, overflow}, 64'd1);
            end
        end
        drain(300);
        check("ovf_count", 64'(po_cyc.size()), 64'd9);
        if (po_cyc.size() == 9) begin
            for (int i = 1; i < 9; i++) check("ovf_spacing", 64'(po_cyc[i] - po_cyc[i-1]), 64'd3);
        end
        check("ovf_sticky", {63'd0, overflow}, 64'd1);
        check("full_cleared", {63'd0, full}, 64'd0);

        // Explicit seed reload, then seed=0 together with a request
        seedload = 1'b1; seed = DEF_SEED; m_lfsr = DEF_SEED;
        @(negedge clk);
        seedload = 1'b0;
        push(1'b0, 1'b1);
        drain(20);
        check("seed_explicit_Z", 64'(Z), 64'h0123);
        seedload = 1'b1; seed = '0; m_lfsr = DEF_SEED;
        push(1'b0, 1'b1);
        seedload = 1'b0;
        drain(20);
        check("seed_zero_Z", 64'(Z), 64'h0123);

        // Reseed four draws into a mode-1 sum: the remaining eight come from SEED2
        s = m_sum(4);
        m_lfsr = SEED2;
        s += m_sum(8);
        exp_q.push_back(ZW'(s - int'(NSUM) * (1 << (UW - 1))));
        push(1'b1, 1'b0);
        repeat (4) @(negedge clk);
        seedload = 1'b1; seed = SEED2;
        @(negedge clk);
        seedload = 1'b0;
        drain(40);

        // Reset while pushout is high drops it without waiting for a clock
        @(negedge clk);
        assert_rst();
        release_rst();
        push(1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("po_before_rst", {63'd0, pushout}, 64'd1);
        assert_rst();
        check("rst_async_pushout", {63'd0, pushout}, 64'd0);
        check("rst_async_Z", 64'(Z), 64'd0);
        release_rst();

        // Reset during ACC with three requests queued
        push(1'b1, 1'b1);
        push(1'b0, 1'b1);
        push(1'b0, 1'b1);
        push(1'b0, 1'b1);
        @(negedge clk);
        assert_rst();
        check("rst_acc_pushout", {63'd0, pushout}, 64'd0);
        check("rst_acc_full", {63'd0, full}, 64'd0);
        release_rst();
        repeat (40) @(negedge clk);
        check("rst_acc_no_pushout", 64'(po_cyc.size()), 64'd0);
        push(1'b0, 1'b1);
        drain(20);
        check("rst_acc_first_Z", 64'(Z), 64'h0123);

        // Statistics of mode-1 samples with random request gaps
        stats_on = 1'b1;
        for (int i = 0; i < int'(NSTAT); i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            wait_not_full();
            push(1'b1, 1'b1);
        end
        drain(400);
        stats_on = 1'b0;
        check("stat_count", 64'(n_stat), 64'(NSTAT));
        mean = (n_stat > 0) ? s1 / real'(n_stat) : 0.0;
        sd   = (n_stat > 0) ? $sqrt(s2 / real'(n_stat) - mean * mean) : 0.0;
        // Successive draws share UW-1 bits (lag-j covariance = var/2^j), so the
        // 12-draw sum has 32/12 the variance of an independent Irwin-Hall sum.
        sd_exp = 65536.0 * $sqrt(32.0 / 12.0);
        $display("stats: mean %f sd %f reference sd %f", mean, sd, sd_exp);
        check("stat_mean", {63'd0, (mean <= 0.05 * 65536.0) && (mean >= -0.05 * 65536.0)}, 64'd1);
        check("stat_sd", {63'd0, (sd <= 1.05 * sd_exp) && (sd >= 0.95 * sd_exp)}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
